// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Holds the controller state encoding and the default timeout and
// stall-counter width used by pipeline_ctrl.
package pipe_ctrl_pkg;

  localparam int MEM_TIMEOUT_DEF = 4;
  localparam int CNT_W_DEF       = 16;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_ERROR      = 2'd3
  } pipe_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in ID/EX whose destination register
// (never R0) is read by the instruction currently in IF/ID.
// Ports:
//   mem_read  - ID/EX instruction is a load
//   idex_rt   - load destination register
//   ifid_rs   - source register 1 of the IF/ID instruction
//   ifid_rt   - source register 2 of the IF/ID instruction
//   load_use  - hazard present this cycle
module hazard_detect (
  input  logic       mem_read,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       load_use
);

  assign load_use = mem_read && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: freezes, flushes and bubbles the five-stage pipeline
// for load-use hazards, taken branches and data-memory waits, and traps
// into a sticky ERROR state when memory stays busy too long.
// Ports:
//   clk_i, rst_i             - clock, synchronous active-low reset
//   IDEX_MemRead_i, IDEX_RT_i, IFID_RS_i, IFID_RT_i - load-use operands
//   branch_taken_i           - taken branch resolved in EX/MEM
//   dmem_req_i, dmem_ready_i - data-memory access / completion
//   PC_write_o, IFID_write_o, EXMEM_write_o - register write enables
//   IFID_flush_o, IDEX_bubble_o, EXMEM_bubble_o, MEMWB_bubble_o - zero stage
//   state_o                  - current controller state (debug visibility)
//   error_o                  - sticky timeout flag
//   stall_cnt_o              - saturating count of cycles with PC frozen
//
// Memory handshake: EX/MEM holds an access while dmem_req_i is high; the
// access completes in a cycle where dmem_ready_i is high. Every cycle the
// access is pending without ready is a wait cycle. Once in MEM_WAIT only
// dmem_ready_i is considered, since the request is already committed.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RT_i,
  input  logic [4:0]       IFID_RS_i,
  input  logic [4:0]       IFID_RT_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             EXMEM_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_bubble_o,
  output logic             EXMEM_bubble_o,
  output logic             MEMWB_bubble_o,
  output logic [1:0]       state_o,
  output logic             error_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  pipe_state_e       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [WAIT_W:0]   wait_cycle;
  logic              load_use;
  logic              mem_hold;

  hazard_detect u_hazard (
    .mem_read (IDEX_MemRead_i),
    .idex_rt  (IDEX_RT_i),
    .ifid_rs  (IFID_RS_i),
    .ifid_rt  (IFID_RT_i),
    .load_use (load_use)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      stall_cnt_o <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (!PC_write_o && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt      = state;
    wait_nxt       = '0;
    PC_write_o     = 1'b1;
    IFID_write_o   = 1'b1;
    EXMEM_write_o  = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_bubble_o  = 1'b0;
    EXMEM_bubble_o = 1'b0;
    MEMWB_bubble_o = 1'b0;

    // Ordinal of the current wait cycle if memory is still busy; the first
    // wait cycle is the RUN/LOAD_STALL cycle that sees the pending access.
    wait_cycle = {1'b0, (state == ST_MEM_WAIT) ? wait_cnt : WAIT_W'(0)} +
                 (WAIT_W + 1)'(1);
    mem_hold   = (state == ST_MEM_WAIT) ? !dmem_ready_i
                                        : (dmem_req_i && !dmem_ready_i);

    case (state)
      ST_ERROR: begin
        PC_write_o     = 1'b0;
        IFID_write_o   = 1'b0;
        EXMEM_write_o  = 1'b0;
        MEMWB_bubble_o = 1'b1;
        wait_nxt       = wait_cnt;
        state_nxt      = ST_ERROR;
      end
      default: begin
        if (mem_hold) begin
          PC_write_o     = 1'b0;
          IFID_write_o   = 1'b0;
          EXMEM_write_o  = 1'b0;
          MEMWB_bubble_o = 1'b1;
          wait_nxt       = wait_cycle[WAIT_W-1:0];
          state_nxt      = (wait_cycle >= (WAIT_W + 1)'(MEM_TIMEOUT)) ? ST_ERROR
                                                                      : ST_MEM_WAIT;
        end else if (branch_taken_i) begin
          IFID_flush_o   = 1'b1;
          IDEX_bubble_o  = 1'b1;
          EXMEM_bubble_o = 1'b1;
          state_nxt      = ST_RUN;
        end else if (load_use && (state != ST_LOAD_STALL)) begin
          // A single bubble resolves the hazard, so the stall cycle itself
          // does not re-detect it.
          PC_write_o    = 1'b0;
          IFID_write_o  = 1'b0;
          IDEX_bubble_o = 1'b1;
          state_nxt     = ST_LOAD_STALL;
        end else begin
          state_nxt = ST_RUN;
        end
      end
    endcase

    // Reset holds the whole pipeline frozen and empty.
    if (!rst_i) begin
      PC_write_o     = 1'b0;
      IFID_write_o   = 1'b0;
      EXMEM_write_o  = 1'b0;
      IFID_flush_o   = 1'b1;
      IDEX_bubble_o  = 1'b1;
      EXMEM_bubble_o = 1'b1;
      MEMWB_bubble_o = 1'b1;
    end
  end

  assign state_o = state;
  assign error_o = (state == ST_ERROR);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations
// followed by randomized stimulus, all checked every cycle against a
// behavioural model of the controller rules.
module tb_pipeline_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_RT_i, IFID_RS_i, IFID_RT_i;
  logic             branch_taken_i, dmem_req_i, dmem_ready_i;
  logic             PC_write_o, IFID_write_o, EXMEM_write_o;
  logic             IFID_flush_o, IDEX_bubble_o, EXMEM_bubble_o, MEMWB_bubble_o;
  logic [1:0]       state_o;
  logic             error_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_RT_i      (IDEX_RT_i),
    .IFID_RS_i      (IFID_RS_i),
    .IFID_RT_i      (IFID_RT_i),
    .branch_taken_i (branch_taken_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ready_i   (dmem_ready_i),
    .PC_write_o     (PC_write_o),
    .IFID_write_o   (IFID_write_o),
    .EXMEM_write_o  (EXMEM_write_o),
    .IFID_flush_o   (IFID_flush_o),
    .IDEX_bubble_o  (IDEX_bubble_o),
    .EXMEM_bubble_o (EXMEM_bubble_o),
    .MEMWB_bubble_o (MEMWB_bubble_o),
    .state_o        (state_o),
    .error_o        (error_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks: trapped in error, how many consecutive wait cycles so far,
  // whether the previous cycle inserted a load-use bubble, stalled cycles.
  bit m_err = 0;
  int m_waits = 0;
  bit m_pend = 0;
  int m_cnt = 0;

  bit e_pc, e_ifid, e_exmem, e_flush, e_idb, e_exb, e_mwb, hz, busy;
  int e_state, e_err, e_cnt;

  always @(negedge clk_i) begin
    e_state = m_err ? 3 : (m_waits > 0 ? 2 : (m_pend ? 1 : 0));
    e_err   = m_err ? 1 : 0;
    e_cnt   = m_cnt;
    hz = IDEX_MemRead_i && (IDEX_RT_i != 0) &&
         (IDEX_RT_i == IFID_RS_i || IDEX_RT_i == IFID_RT_i);
    {e_pc, e_ifid, e_exmem} = 3'b111;
    {e_flush, e_idb, e_exb, e_mwb} = 4'b0000;
    if (!rst_i) begin
      {e_pc, e_ifid, e_exmem} = 3'b000;
      {e_flush, e_idb, e_exb, e_mwb} = 4'b1111;
      m_err = 0; m_waits = 0; m_pend = 0; m_cnt = 0;
    end else if (m_err) begin
      {e_pc, e_ifid, e_exmem} = 3'b000;
      e_mwb = 1;
    end else begin
      busy = (m_waits > 0) ? !dmem_ready_i : (dmem_req_i && !dmem_ready_i);
      if (busy) begin
        {e_pc, e_ifid, e_exmem} = 3'b000;
        e_mwb = 1;
        m_waits++;
        m_pend = 0;
        if (m_waits >= MEM_TIMEOUT) m_err = 1;
      end else begin
        m_waits = 0;
        if (branch_taken_i) begin
          {e_flush, e_idb, e_exb} = 3'b111;
          m_pend = 0;
        end else if (hz && !m_pend) begin
          e_pc = 0; e_ifid = 0; e_idb = 1;
          m_pend = 1;
        end else begin
          m_pend = 0;
        end
      end
    end
    if (rst_i && !e_pc && m_cnt < CNT_MAX) m_cnt++;

    chk("PC_write_o",     int'(PC_write_o),     int'(e_pc));
    chk("IFID_write_o",   int'(IFID_write_o),   int'(e_ifid));
    chk("EXMEM_write_o",  int'(EXMEM_write_o),  int'(e_exmem));
    chk("IFID_flush_o",   int'(IFID_flush_o),   int'(e_flush));
    chk("IDEX_bubble_o",  int'(IDEX_bubble_o),  int'(e_idb));
    chk("EXMEM_bubble_o", int'(EXMEM_bubble_o), int'(e_exb));
    chk("MEMWB_bubble_o", int'(MEMWB_bubble_o), int'(e_mwb));
    chk("state_o",        int'(state_o),        e_state);
    chk("error_o",        int'(error_o),        e_err);
    chk("stall_cnt_o",    int'(stall_cnt_o),    e_cnt);
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after posedge; apply() leaves them settled
  // for combinational spot checks before the negedge compare.
  task automatic apply(input logic rst, input logic mr, input logic [4:0] xrt,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic req, input logic rdy);
    rst_i = rst; IDEX_MemRead_i = mr; IDEX_RT_i = xrt;
    IFID_RS_i = rs; IFID_RT_i = rt; branch_taken_i = br;
    dmem_req_i = req; dmem_ready_i = rdy;
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  int rdy_pct;

  initial begin
    do_reset();
    chk("lit_reset_state", int'(state_o), 0);
    chk("lit_reset_cnt", int'(stall_cnt_o), 0);

    // Load-use on R8
    apply(1, 1, 8, 8, 3, 0, 0, 0);
    chk("lit_lu_pc", int'(PC_write_o), 0);
    chk("lit_lu_idb", int'(IDEX_bubble_o), 1);
    tick();
    chk("lit_lu_state1", int'(state_o), 1);
    apply(1, 1, 8, 8, 3, 0, 0, 0);
    chk("lit_lu_suppressed_pc", int'(PC_write_o), 1);
    tick();
    chk("lit_lu_state0", int'(state_o), 0);
    chk("lit_lu_cnt", int'(stall_cnt_o), 1);

    // R0 never hazards
    do_reset();
    apply(1, 1, 0, 5, 0, 0, 0, 0);
    chk("lit_r0_pc", int'(PC_write_o), 1);
    tick();
    chk("lit_r0_cnt", int'(stall_cnt_o), 0);

    // Branch wins over load-use
    do_reset();
    apply(1, 1, 7, 1, 7, 1, 0, 0);
    chk("lit_br_flush", {29'd0, IFID_flush_o, IDEX_bubble_o, EXMEM_bubble_o}, 7);
    chk("lit_br_pc", int'(PC_write_o), 1);
    tick();
    chk("lit_br_state", int'(state_o), 0);

    // Memory wait of three cycles, then release
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 0, 0, 0, 1, 0);
      chk("lit_mw_frozen", {30'd0, PC_write_o, MEMWB_bubble_o}, 1);
      tick();
    end
    chk("lit_mw_state", int'(state_o), 2);
    apply(1, 0, 0, 0, 0, 1, 1, 1);
    chk("lit_mw_release", {29'd0, PC_write_o, IFID_write_o, EXMEM_write_o}, 7);
    tick();
    chk("lit_mw_cnt", int'(stall_cnt_o), 3);
    chk("lit_mw_state0", int'(state_o), 0);

    // Timeout into ERROR, saturation, then reset clears it
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
    chk("lit_to_state", int'(state_o), 3);
    chk("lit_to_err", int'(error_o), 1);
    chk("lit_to_cnt", int'(stall_cnt_o), 4);
    for (int i = 0; i < 6; i++) begin
      apply(1, 1, 2, 2, 2, 1, 0, 1);
      tick();
    end
    chk("lit_to_sat", int'(stall_cnt_o), CNT_MAX);
    chk("lit_to_hold", int'(state_o), 3);
    do_reset();
    chk("lit_to_rst_state", int'(state_o), 0);
    chk("lit_to_rst_err", int'(error_o), 0);
    chk("lit_to_rst_cnt", int'(stall_cnt_o), 0);

    // Reset during the second MEM_WAIT cycle
    apply(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    chk("lit_rmw_pc", int'(PC_write_o), 0);
    chk("lit_rmw_bub", {28'd0, IFID_flush_o, IDEX_bubble_o, EXMEM_bubble_o, MEMWB_bubble_o}, 15);
    tick();
    chk("lit_rmw_state", int'(state_o), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rdy_pct = ((i / 500) % 2 == 0) ? 70 : 30;
      apply(($urandom_range(0, 39) != 0),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 99) < rdy_pct));
      tick();
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
